// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle controller: FSM states, instruction
// classes and the datapath mux select constants.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } statetype;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } optype;

  localparam logic [1:0] ALUSRCA_REG    = 2'b00;
  localparam logic [1:0] ALUSRCA_PC     = 2'b01;

  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b01;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b10;

  localparam logic [1:0] RESULT_ALUOUT  = 2'b00;
  localparam logic [1:0] RESULT_DATA    = 2'b01;
  localparam logic [1:0] RESULT_ALU     = 2'b10;

endpackage

// File: rtl/mainfsm_flopr.sv
// Resettable register with a synchronous active-high reset to a
// configurable value; holds the controller state.
module mainfsm_flopr #(
  parameter int unsigned          WIDTH    = 4,
  parameter logic [WIDTH-1:0]     RESETVAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RESETVAL;
    else       q <= d;
  end

endmodule

// File: rtl/mainfsm.sv
// Multicycle processor main controller: Moore FSM sequencing fetch, decode
// and the per-class execute steps; outputs depend on the current state only.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp
);

  logic [3:0] state;
  logic [3:0] nextstate;

  // Funct[4:1] select the ALU operation downstream, not the sequencing.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  mainfsm_flopr #(
    .WIDTH    (4),
    .RESETVAL (FETCH)
  ) statereg (
    .clk   (clk),
    .reset (reset),
    .d     (nextstate),
    .q     (state)
  );

  always_comb begin
    nextstate = FETCH;
    case (state)
      FETCH:    nextstate = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  nextstate = MEMADR;
          OP_DP:   nextstate = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   nextstate = BRANCH;
          default: nextstate = UNKNOWN;
        endcase
      end
      MEMADR:   nextstate = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    nextstate = MEMWB;
      MEMWB:    nextstate = FETCH;
      MEMWR:    nextstate = FETCH;
      EXECUTER: nextstate = ALUWB;
      EXECUTEI: nextstate = ALUWB;
      ALUWB:    nextstate = FETCH;
      BRANCH:   nextstate = FETCH;
      UNKNOWN:  nextstate = FETCH;
      default:  nextstate = FETCH;
    endcase
  end

  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = ALUSRCA_REG;
    ALUSrcB   = ALUSRCB_REG;
    ResultSrc = RESULT_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = ALUSRCA_PC;
        ALUSrcB   = ALUSRCB_FOUR;
        ResultSrc = RESULT_ALU;
        NextPC    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = ALUSRCA_PC;
        ALUSrcB   = ALUSRCB_FOUR;
        ResultSrc = RESULT_ALU;
      end
      MEMADR: begin
        ALUSrcB   = ALUSRCB_IMM;
      end
      MEMRD: begin
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = RESULT_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
      end
      EXECUTER: begin
        ALUOp     = 1'b1;
      end
      EXECUTEI: begin
        ALUSrcB   = ALUSRCB_IMM;
        ALUOp     = 1'b1;
      end
      ALUWB: begin
        RegW      = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = ALUSRCB_IMM;
        ResultSrc = RESULT_ALU;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mainfsm.sv
// Self-checking bench for mainfsm: instruction-level model of the expected
// per-cycle control vectors, randomized instruction streams and resets.
module tb_mainfsm;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op    = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

  mainfsm dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp)
  );

  always #5 clk = ~clk;

  // {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp}
  logic [12:0] outv;
  assign outv = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};

  localparam logic [12:0] V_FETCH  = 13'b1_0_01_10_10_1_0_0_0_0;
  localparam logic [12:0] V_DECODE = 13'b0_0_01_10_10_0_0_0_0_0;
  localparam logic [12:0] V_MEMADR = 13'b0_0_00_01_00_0_0_0_0_0;
  localparam logic [12:0] V_MEMRD  = 13'b0_1_00_00_00_0_0_0_0_0;
  localparam logic [12:0] V_MEMWB  = 13'b0_0_00_00_01_0_1_0_0_0;
  localparam logic [12:0] V_MEMWR  = 13'b0_1_00_00_00_0_0_1_0_0;
  localparam logic [12:0] V_EXECR  = 13'b0_0_00_00_00_0_0_0_0_1;
  localparam logic [12:0] V_EXECI  = 13'b0_0_00_01_00_0_0_0_0_1;
  localparam logic [12:0] V_ALUWB  = 13'b0_0_00_00_00_0_1_0_0_0;
  localparam logic [12:0] V_BRANCH = 13'b0_0_00_01_10_0_0_0_1_0;

  logic [12:0] expq[$];
  logic [12:0] obs[$];
  int checks = 0;
  int fails  = 0;

  // Instruction latency, FETCH to next FETCH.
  function automatic int ilen(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b01:   return f[0] ? 5 : 4;
      2'b00:   return 4;
      default: return 3;
    endcase
  endfunction

  // Control vector expected in cycle k of an instruction of this class.
  function automatic logic [12:0] ivec(input logic [1:0] op, input logic [5:0] f, input int k);
    if (k == 0) return V_FETCH;
    if (k == 1) return V_DECODE;
    case (op)
      2'b01: begin
        if (k == 2) return V_MEMADR;
        if (f[0])   return (k == 3) ? V_MEMRD : V_MEMWB;
        return V_MEMWR;
      end
      2'b00:   return (k == 2) ? (f[5] ? V_EXECI : V_EXECR) : V_ALUWB;
      2'b10:   return V_BRANCH;
      default: return 13'b0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one instruction; Op/Funct carry the real instruction only in the
  // cycles where they are decoded and are random noise elsewhere.
  task automatic run_instr(input logic [1:0] op, input logic [5:0] f, input int abort_at);
    int n;
    n = ilen(op, f);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      expq.push_back(ivec(op, f, k));
      reset = (k == abort_at);
      if (k == 1 || (k == 2 && op == 2'b01)) begin
        Op    = op;
        Funct = f;
      end else begin
        Op    = 2'($urandom);
        Funct = 6'($urandom);
      end
      if (k == abort_at) break;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      obs.push_back(outv);
      checks++;
      if (outv !== e) begin
        fails++;
        $display("FAIL cycle_outputs @%0t: got %b expected %b", $time, outv, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] rop;
    logic [5:0] rf;
    int         ab;

    reset = 1'b1;
    Op    = 2'b10;
    repeat (2) begin
      @(posedge clk);
      #1;
      expq.push_back(V_FETCH);
    end

    run_instr(2'b10, 6'b000000, -1);   // obs 2..4   branch
    run_instr(2'b01, 6'b000001, -1);   // obs 5..9   load
    run_instr(2'b01, 6'b000000, -1);   // obs 10..13 store
    run_instr(2'b00, 6'b100100, -1);   // obs 14..17 add immediate
    run_instr(2'b00, 6'b000100, -1);   // obs 18..21 add register
    run_instr(2'b11, 6'b000000, -1);   // obs 22..24 undefined
    run_instr(2'b01, 6'b000000, 3);    // obs 25..28 store, reset in MEMWR
    run_instr(2'b10, 6'b000000, -1);   // obs 29..31
    settle();

    check("obs_count",          obs.size(), 32);
    check("reset_state",        int'(obs[0]), int'(13'b1_0_01_10_10_1_0_0_0_0));
    check("br_nextpc_c1",       int'(obs[2][4]), 1);
    check("br_branch_c2",       int'(obs[3][1]), 0);
    check("br_branch_c3",       int'(obs[4][1]), 1);
    check("br_nextpc_c3",       int'(obs[4][4]), 0);
    check("br_nextpc_c4",       int'(obs[5][4]), 1);
    check("ld_memadr_regw",     int'(obs[7][3]), 0);
    check("ld_memwb_regw",      int'(obs[9][3]), 1);
    check("ld_memwb_resultsrc", int'(obs[9][6:5]), 1);
    check("st_memw",            int'(obs[13][2]), 1);
    check("st_adrsrc",          int'(obs[13][11]), 1);
    check("st_regw",            int'(obs[13][3]), 0);
    check("addi_alusrcb",       int'(obs[16][8:7]), 1);
    check("addi_aluop",         int'(obs[16][0]), 1);
    check("addi_aluwb_regw",    int'(obs[17][3]), 1);
    check("add_alusrcb",        int'(obs[20][8:7]), 0);
    check("und_all_zero",       int'(obs[24]), 0);
    check("und_then_fetch",     int'(obs[25]), int'(13'b1_0_01_10_10_1_0_0_0_0));
    check("abort_memwr_memw",   int'(obs[28][2]), 1);
    check("abort_next_memw",    int'(obs[29][2]), 0);
    check("abort_next_irwrite", int'(obs[29][12]), 1);

    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom);
      rf  = 6'($urandom);
      if ($urandom_range(0, 9) == 0)
        ab = int'($urandom_range(0, 32'(ilen(rop, rf) - 1)));
      else
        ab = -1;
      run_instr(rop, rf, ab);
    end
    settle();
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mainfsm.md
MAINFSM -- requirements
Module: mainfsm

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 Op  input  2  instruction class, Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-005 Funct  input  6  Instr[25:20]; bit5 = immediate flag I, bit0 = load/store select L.
REQ-006 IRWrite  output  1  instruction register load enable.
REQ-007 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-008 ALUSrcA  output  2  ALU A select: 00 = register A, 01 = PC; 10/11 are never driven.
REQ-009 ALUSrcB  output  2  ALU B select: 00 = register, 01 = ExtImm, 10 = constant 4.
REQ-010 ResultSrc  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALU result.
REQ-011 NextPC  output  1  unconditional PC write request to the conditional-write logic.
REQ-012 RegW  output  1  register write request, gated downstream by CondEx.
REQ-013 MemW  output  1  memory write request, gated downstream by CondEx.
REQ-014 Branch  output  1  branch request; becomes PCS after OR with a write to R15.
REQ-015 ALUOp  output  1  1 = the ALU decoder uses Funct; 0 = add.

Function
REQ-016 The block SHALL be a Moore FSM with 11 states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
REQ-017 All outputs SHALL be a combinational function of the current state only, with no input-to-output path.
REQ-018 Any output not listed for a state SHALL be 0.
REQ-019 FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, NextPC=1. Next state is DECODE.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by decode:
- Op=01 -> MEMADR
- Op=00 with Funct[5]=0 -> EXECUTER
- Op=00 with Funct[5]=1 -> EXECUTEI
- Op=10 -> BRANCH
- Op=11 -> UNKNOWN
REQ-021 MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0. Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
REQ-022 MEMRD: AdrSrc=1, ResultSrc=00. Next state is MEMWB.
REQ-023 MEMWB: ResultSrc=01, RegW=1. Next state is FETCH.
REQ-024 MEMWR: AdrSrc=1, ResultSrc=00, MemW=1. Next state is FETCH.
REQ-025 EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1. Next state is ALUWB.
REQ-026 EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1. Next state is ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegW=1. Next state is FETCH.
- This is the cycle in which the one-cycle-delayed flag write commits.
REQ-028 BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1, ALUOp=0. Next state is FETCH.
REQ-029 UNKNOWN: all outputs 0. Next state is FETCH, so an undefined instruction costs 3 cycles and performs no writes.
REQ-030 Instruction latencies in cycles, FETCH to next FETCH:
- load 5, store 4
- data-processing 4
- branch 3
REQ-031 Op and Funct SHALL be sampled only in DECODE and MEMADR; they are ignored in every other state.
REQ-032 Unused state encodings SHALL transition to FETCH and drive all outputs to 0.

Reset
REQ-033 While reset=1 at a rising edge, the next state SHALL be FETCH regardless of the current state or the inputs.
REQ-034 Outputs after reset SHALL equal the FETCH values: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, all others 0.
REQ-035 Reset asserted mid-instruction (e.g. in MEMWR) SHALL abort the instruction with no further MemW or RegW pulse.

Structure
REQ-036 The 4-bit state encodings and the ALUSrcA, ALUSrcB and ResultSrc select constants SHALL live in a shared package, also used by the datapath muxes.
REQ-037 The state register SHALL be a single sub-module instance: 4-bit flopr, reset value FETCH.
REQ-038 Next-state logic and output decode SHALL be separate combinational blocks.

Verification
REQ-039 Reset held for 2 cycles, then released with Op=10 -> state sequence FETCH, DECODE, BRANCH, FETCH; Branch=1 only in cycle 3; NextPC=1 only in cycles 1 and 4.
REQ-040 Op=01, Funct=000001 (load) -> FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegW=1 and ResultSrc=01 only in MEMWB; MemW never 1.
REQ-041 Op=01, Funct=000000 (store) -> MemW=1 and AdrSrc=1 for exactly one cycle, in state 4; RegW stays 0.
REQ-042 Op=00, Funct=100100 (ADD immediate) -> EXECUTEI with ALUSrcB=01 and ALUOp=1, then ALUWB with RegW=1; repeat with Funct=000100 -> EXECUTER with ALUSrcB=00.
REQ-043 Op=11 -> UNKNOWN for one cycle with all outputs 0, then FETCH; Op toggled outside DECODE changes no transition.
REQ-044 Reset asserted during MEMWR -> next cycle in FETCH, MemW=0, IRWrite=1.
